// File: rtl/post_norm_addsub.sv
// Post-normalization for the FP add/sub path: normalize, round, pack IEEE-754 single.
// Three-stage pipeline that stalls as a unit; POST_NORM_FTZ_EN flushes denormal results to zero.
module post_norm_addsub (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] fract_in,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    input  logic        result_zero_sign,
    input  logic        nan_sign,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic [1:0]  rmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        ine,
    output logic        overflow,
    output logic        underflow,
    output logic        zero
);

    typedef struct packed {
        logic       sign;
        logic       zsign;
        logic       nsign;
        logic       nan;
        logic       inf;
        logic       fzero;
        logic [1:0] rmode;
    } side_t;

    logic advance;
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    // ---------------- stage 1: normalize control ----------------
    logic [8:0]  e_base, e_lim;
    logic [4:0]  lz;
    logic [26:0] f1_next;
    logic        st1_next;
    logic [8:0]  e1_next;
    logic [4:0]  sh1_next;
    side_t       side1_next;

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (fract_in[i]) lz = 5'(26 - i);
        end
    end

    always_comb begin
        e_base = (exp_in == 8'd0) ? 9'd1 : {1'b0, exp_in};
        e_lim  = e_base - 9'd1;
        if (fract_in[27]) begin
            f1_next  = fract_in[27:1];
            st1_next = fract_in[0];
            e1_next  = e_base + 9'd1;
            sh1_next = 5'd0;
        end else begin
            f1_next  = fract_in[26:0];
            st1_next = 1'b0;
            e1_next  = e_base;
            // never shift below the minimum exponent: the remainder stays denormal
            sh1_next = ({4'b0, lz} <= e_lim) ? lz : e_lim[4:0];
        end
        side1_next = '{sign: sign_in, zsign: result_zero_sign, nsign: nan_sign,
                       nan: in_nan, inf: in_inf, fzero: (fract_in == 28'd0), rmode: rmode};
    end

    logic        s1_valid_reg;
    logic [26:0] f1_reg;
    logic        st1_reg;
    logic [8:0]  e1_reg;
    logic [4:0]  sh1_reg;
    side_t       side1_reg;

    // ---------------- stage 2: shift and round ----------------
    logic [26:0] fs;
    logic [8:0]  e_sh;
    logic        g, r, st, lsb, grs, inc;
    logic [24:0] mant_r;
    logic [8:0]  exp2_next;
    logic [22:0] frac2_next;

    always_comb begin
        fs   = f1_reg << sh1_reg;
        e_sh = e1_reg - {4'b0, sh1_reg};
        g    = fs[2];
        r    = fs[1];
        st   = fs[0] | st1_reg;
        lsb  = fs[3];
        grs  = g | r | st;
        case (side1_reg.rmode)
            2'd0:    inc = g & (r | st | lsb);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !side1_reg.sign & grs;
            default: inc = side1_reg.sign & grs;
        endcase
        mant_r = {1'b0, fs[26:3]} + {24'd0, inc};
        // a missing hidden bit after rounding means a denormal (field 0); gaining it means exponent 1
        if (mant_r[24]) begin
            exp2_next  = e_sh + 9'd1;
            frac2_next = mant_r[23:1];
        end else begin
            exp2_next  = mant_r[23] ? e_sh : 9'd0;
            frac2_next = mant_r[22:0];
        end
    end

    logic        s2_valid_reg;
    logic [8:0]  exp2_reg;
    logic [22:0] frac2_reg;
    logic        inexact2_reg;
    side_t       side2_reg;

    // ---------------- stage 3: pack and specials ----------------
    logic [31:0] out_next;
    logic        ine_next, ovf_next, unf_next, zero_next;
    logic        away;

    always_comb begin
        out_next  = {side2_reg.sign, exp2_reg[7:0], frac2_reg};
        ine_next  = inexact2_reg;
        ovf_next  = 1'b0;
        unf_next  = (exp2_reg == 9'd0) && inexact2_reg;
        zero_next = 1'b0;
        away      = (side2_reg.rmode == 2'd1) ||
                    (side2_reg.rmode == 2'd2 &&  side2_reg.sign) ||
                    (side2_reg.rmode == 2'd3 && !side2_reg.sign);
        if (side2_reg.nan) begin
            out_next = {side2_reg.nsign, 8'hFF, 23'h400000};
            ine_next = 1'b0;
            unf_next = 1'b0;
        end else if (side2_reg.inf) begin
            out_next = {side2_reg.sign, 8'hFF, 23'h0};
            ine_next = 1'b0;
            unf_next = 1'b0;
        end else if (side2_reg.fzero) begin
            out_next  = {side2_reg.zsign, 31'b0};
            ine_next  = 1'b0;
            unf_next  = 1'b0;
            zero_next = 1'b1;
        end else if (exp2_reg >= 9'd255) begin
            out_next = away ? {side2_reg.sign, 8'hFE, 23'h7FFFFF} : {side2_reg.sign, 8'hFF, 23'h0};
            ine_next = 1'b1;
            ovf_next = 1'b1;
            unf_next = 1'b0;
        end else begin
`ifdef POST_NORM_FTZ_EN
            if (exp2_reg == 9'd0 && frac2_reg != 23'd0) begin
                out_next  = {side2_reg.sign, 31'b0};
                zero_next = 1'b1;
                unf_next  = 1'b1;
                ine_next  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            f1_reg       <= '0;
            st1_reg      <= 1'b0;
            e1_reg       <= '0;
            sh1_reg      <= '0;
            side1_reg    <= '0;
            s2_valid_reg <= 1'b0;
            exp2_reg     <= '0;
            frac2_reg    <= '0;
            inexact2_reg <= 1'b0;
            side2_reg    <= '0;
            out_valid    <= 1'b0;
            out          <= '0;
            ine          <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            zero         <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s2_valid_reg <= s1_valid_reg;
            out_valid    <= s2_valid_reg;
            if (in_valid) begin
                f1_reg    <= f1_next;
                st1_reg   <= st1_next;
                e1_reg    <= e1_next;
                sh1_reg   <= sh1_next;
                side1_reg <= side1_next;
            end
            if (s1_valid_reg) begin
                exp2_reg     <= exp2_next;
                frac2_reg    <= frac2_next;
                inexact2_reg <= grs;
                side2_reg    <= side1_reg;
            end
            if (s2_valid_reg) begin
                out       <= out_next;
                ine       <= ine_next;
                overflow  <= ovf_next;
                underflow <= unf_next;
                zero      <= zero_next;
            end
        end
    end

endmodule

// File: tb/tb_post_norm_addsub.sv
// Bench for post_norm_addsub: directed cases, backpressure, reset flush and random beats vs a value-level model.
module tb_post_norm_addsub;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] fract_in = '0;
    logic [7:0]  exp_in = '0;
    logic        sign_in = 1'b0;
    logic        result_zero_sign = 1'b0;
    logic        nan_sign = 1'b0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic [1:0]  rmode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        ine, overflow, underflow, zero;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    typedef struct packed {
        logic [31:0] out;
        logic        ine;
        logic        ovf;
        logic        unf;
        logic        zero;
    } res_t;

    res_t exp_q[$];

    always #5 clk = ~clk;

    post_norm_addsub dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fract_in(fract_in), .exp_in(exp_in), .sign_in(sign_in),
        .result_zero_sign(result_zero_sign), .nan_sign(nan_sign),
        .in_nan(in_nan), .in_inf(in_inf), .rmode(rmode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .ine(ine), .overflow(overflow), .underflow(underflow), .zero(zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Value-level reference: the exact value fract*2^(E-153) is requantized onto the
    // target exponent's ulp grid and rounded from the discarded remainder.
    function automatic res_t model(input logic [27:0] fr, input logic [7:0] ex, input logic sg,
                                   input logic zs, input logic ns, input logic nan, input logic inf,
                                   input logic [1:0] rm);
        res_t r;
        logic [63:0] f64, m, rem, half;
        int e, msb, be, k, fld;
        logic inc, away;
        r = '0;
        if (nan) begin r.out = {ns, 8'hFF, 23'h400000}; return r; end
        if (inf) begin r.out = {sg, 8'hFF, 23'h0}; return r; end
        if (fr == 28'd0) begin r.out = {zs, 31'b0}; r.zero = 1'b1; return r; end
        e = (ex == 8'd0) ? 1 : int'(ex);
        msb = 0;
        for (int i = 0; i < 28; i++) if (fr[i]) msb = i;
        be = e + msb - 26;
        if (be < 1) be = 1;
        k = e - be - 3;
        f64 = {36'd0, fr};
        if (k >= 0) begin
            m = f64 << k; rem = 64'd0; half = 64'd1;
        end else begin
            m = f64 >> (-k);
            rem = f64 & ((64'd1 << (-k)) - 64'd1);
            half = 64'd1 << (-k - 1);
        end
        case (rm)
            2'd0:    inc = (rem > half) || (rem == half && m[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !sg && (rem != 64'd0);
            default: inc = sg && (rem != 64'd0);
        endcase
        m = m + {63'd0, inc};
        if (m == 64'h1000000) begin m = 64'h800000; be++; end
        fld = (m >= 64'h800000) ? be : 0;
        r.ine = (rem != 64'd0);
        if (fld >= 255) begin
            away = (rm == 2'd1) || (rm == 2'd2 && sg) || (rm == 2'd3 && !sg);
            r.out = away ? {sg, 8'hFE, 23'h7FFFFF} : {sg, 8'hFF, 23'h0};
            r.ovf = 1'b1;
            r.ine = 1'b1;
            return r;
        end
        r.out = {sg, fld[7:0], m[22:0]};
        r.unf = (fld == 0) && r.ine;
`ifdef POST_NORM_FTZ_EN
        if (fld == 0 && m[22:0] != 23'd0) begin
            r.out = {sg, 31'b0}; r.zero = 1'b1; r.unf = 1'b1; r.ine = 1'b1;
        end
`endif
        return r;
    endfunction

    // Scoreboard: record accepted beats, compare consumed results in order.
    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(fract_in, exp_in, sign_in, result_zero_sign,
                                      nan_sign, in_nan, in_inf, rmode));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out", out, e.out);
                    chk("sb_flags", {28'd0, ine, overflow, underflow, zero},
                        {28'd0, e.ine, e.ovf, e.unf, e.zero});
                end
            end
        end
    end

    task automatic send(input logic [27:0] fr, input logic [7:0] ex, input logic sg, input logic zs,
                        input logic ns, input logic nan, input logic inf, input logic [1:0] rm);
        bit acc;
        int n;
        fract_in = fr; exp_in = ex; sign_in = sg; result_zero_sign = zs;
        nan_sign = ns; in_nan = nan; in_inf = inf; rmode = rm; in_valid = 1'b1;
        n = 0;
        do begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic directed(input string tag, input logic [27:0] fr, input logic [7:0] ex,
                            input logic sg, input logic zs, input logic ns, input logic nan,
                            input logic inf, input logic [1:0] rm,
                            input logic [31:0] eo, input logic [3:0] eflags);
        int n;
        send(fr, ex, sg, zs, ns, nan, inf, rm);
        n = 1;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_flags"}, {28'd0, ine, overflow, underflow, zero}, {28'd0, eflags});
        idle(1);
    endtask

    initial begin
        int n;
        logic [31:0] held;
        logic [27:0] fr;
        logic [7:0]  ex;
        int sel;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out", out, 32'd0);
        chk("reset_flags", {28'd0, ine, overflow, underflow, zero}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        idle(1);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // flags order: {ine, overflow, underflow, zero}
        directed("one_plus_one", 28'h8000000, 8'd127, 0, 0, 0, 0, 0, 2'd0, 32'h40000000, 4'b0000);
        directed("rne_tie_even", 28'h4000004, 8'd127, 0, 0, 0, 0, 0, 2'd0, 32'h3F800000, 4'b1000);
        directed("rne_tie_odd",  28'h400000C, 8'd127, 0, 0, 0, 0, 0, 2'd0, 32'h3F800002, 4'b1000);
        directed("exact_cancel", 28'h0, 8'd100, 0, 1, 0, 0, 0, 2'd3, 32'h80000000, 4'b0001);
        directed("ovf_rne",      28'h8000000, 8'd254, 0, 0, 0, 0, 0, 2'd0, 32'h7F800000, 4'b1100);
        directed("ovf_rtz",      28'h8000000, 8'd254, 0, 0, 0, 0, 0, 2'd1, 32'h7F7FFFFF, 4'b1100);
        directed("ovf_rup_neg",  28'h8000000, 8'd254, 1, 0, 0, 0, 0, 2'd2, 32'hFF7FFFFF, 4'b1100);
`ifdef POST_NORM_FTZ_EN
        directed("denormal",     28'h1000000, 8'd1, 0, 0, 0, 0, 0, 2'd0, 32'h00000000, 4'b1011);
`else
        directed("denormal",     28'h1000000, 8'd1, 0, 0, 0, 0, 0, 2'd0, 32'h00200000, 4'b0000);
`endif
        directed("denorm_to_min_normal", 28'h3FFFFFC, 8'd1, 0, 0, 0, 0, 0, 2'd0, 32'h00800000, 4'b1000);
        directed("mant_carry",   28'h7FFFFFC, 8'd127, 0, 0, 0, 0, 0, 2'd0, 32'h40000000, 4'b1000);
        directed("rdn_neg",      28'h4000001, 8'd127, 1, 0, 0, 0, 0, 2'd3, 32'hBF800001, 4'b1000);
        directed("nan",          28'h4000001, 8'd200, 0, 0, 1, 1, 1, 2'd0, 32'hFFC00000, 4'b0000);
        directed("inf",          28'h8000000, 8'd254, 1, 0, 0, 0, 1, 2'd1, 32'hFF800000, 4'b0000);

        // backpressure: fill the pipe with the output held
        out_ready = 1'b0;
        send(28'h5A5A5A5, 8'd130, 0, 0, 0, 0, 0, 2'd0);
        send(28'h8123457, 8'd90,  1, 0, 0, 0, 0, 2'd2);
        send(28'h0003F0F, 8'd40,  0, 0, 0, 0, 0, 2'd3);
        fract_in = 28'h7FFFFFF; exp_in = 8'd3; sign_in = 1'b1; rmode = 2'd0; in_valid = 1'b1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        held = out;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_out_stable", out, held);
            chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        send(28'h7FFFFFF, 8'd3, 1, 0, 0, 0, 0, 2'd0);
        send(28'h0000001, 8'd0, 0, 0, 0, 0, 0, 2'd2);
        idle(6);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // reset with beats in flight
        out_ready = 1'b0;
        send(28'h4000000, 8'd127, 0, 0, 0, 0, 0, 2'd0);
        send(28'h6000000, 8'd127, 0, 0, 0, 0, 0, 2'd0);
        idle(1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flush_out", out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // random beats with random output backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 19);
            fr = 28'($urandom) >> $urandom_range(0, 27);
            if (sel == 0) fr = 28'd0;
            ex = (sel < 6) ? 8'($urandom_range(0, 6)) : (sel < 9) ? 8'($urandom_range(248, 255)) : 8'($urandom);
            send(fr, ex, 1'($urandom), 1'($urandom), 1'($urandom),
                 sel == 1, sel == 2, 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/post_norm_addsub.md
# post_norm_addsub

Post-normalization unit for the add/sub datapath. It takes the raw 28-bit adder result, the denormalized exponent and the sign/zero/NaN side information from pre-normalization. It normalizes, rounds per `rmode`, handles special cases, and packs an IEEE-754 single-precision result. It is a 3-stage pipeline with a valid/ready handshake on both sides, and sits between the fraction adder and the FPU result mux.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all flops on rising edge
- `reset`  in  1  reset; one clock; reset is asynchronous and active-low
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  unit accepts beat this cycle
- `fract_in`  in  28  adder result; bit 27 = carry, bit 26 = hidden-bit position, bits 2:0 = guard/round/sticky
- `exp_in`  in  8  large (denormalized) exponent
- `sign_in`  in  1  result sign for nonzero results
- `result_zero_sign`  in  1  sign used when `fract_in` == 0
- `nan_sign`  in  1  sign of NaN result
- `in_nan`  in  1  result is NaN (operand NaN or inf−inf)
- `in_inf`  in  1  result is infinity
- `rmode`  in  2  0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward −inf
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out`  out  32  packed result
- `ine`, `overflow`, `underflow`, `zero`  out  1 each  exception flags, aligned with `out`

## Operation
- Stage 1, normalize control:
  - e = max(`exp_in`, 1).
  - If `fract_in[27]`: right-shift by 1, OR the shifted-out bit into sticky, e = e+1.
  - Else: lz = leading-zero count of `fract_in[26:0]`; shift s = min(lz, e−1).
- Stage 2, shift and round:
  - Left-shift by s; exponent = e−s.
  - If bit 26 is still 0 after the shift, the exponent field is 0 (denormal result).
  - Mantissa = bits 26:3. G = bit 2, R = bit 1, S = bit 0 | accumulated sticky.
  - Increment rules:
    - mode 0: G & (R|S|lsb)
    - mode 1: never
    - mode 2: !sign & (G|R|S)
    - mode 3: sign & (G|R|S)
  - Mantissa carry out: shift right 1, exponent +1.
  - A denormal that rounds to 2^23 becomes exponent 1.
- Stage 3, pack and specials. Priority is NaN > inf > zero > overflow > normal.
  - NaN: {`nan_sign`, 8'hFF, 23'h400000}.
  - Inf: {`sign_in`, 8'hFF, 0}.
  - `fract_in` == 0: {`result_zero_sign`, 31'b0}, `zero` = 1.
  - Exponent ≥ 255: `overflow` = 1, `ine` = 1. Result is ±inf, except that directed modes rounding away from inf give {sign, 8'hFE, 23'h7FFFFF}. That covers mode 1, mode 2 with a negative sign, and mode 3 with a positive sign.
- Flags:
  - `ine` = G|R|S before rounding, or overflow.
  - `underflow` = result exponent field 0 & `ine`.
  - All flags are 0 for NaN and inf results.
- Side information (sign, NaN, inf, rmode) travels with its beat through all stages.

## Timing
- Latency is 3 cycles from accepted beat to `out_valid`. Throughput is 1 beat per cycle.
- A beat is accepted when `in_valid` & `in_ready`. A result is consumed when `out_valid` & `out_ready`.
- `in_ready` = !`out_valid` | `out_ready` (combinational). The whole pipeline stalls as a unit when the output stage is valid and not ready.
- While stalled, `out` and all flags hold stable. No beat is dropped or duplicated, and order is preserved.
- Empty pipeline bubbles propagate and never assert `out_valid`.
- Reset values: `out_valid` 0, `out` 0, all flags 0, all internal valids 0. `in_ready` reads 1 after reset.
- Reset asserted mid-operation discards all in-flight beats immediately.

## Configuration
- `POST_NORM_FTZ_EN` defined: any result whose exponent field is 0 with a nonzero fraction is replaced by {sign, 31'b0}, with `zero`, `underflow` and `ine` set.
- `POST_NORM_FTZ_EN` undefined: gradual underflow, with denormals packed as computed.
- Pipeline latency is identical in both builds.

## Test plan
- 1.0+1.0: `fract_in` 0x8000000, `exp_in` 127, rmode 0 -> `out` 0x40000000, all flags 0, `out_valid` exactly 3 cycles after accept.
- Round to nearest-even:
  - `fract_in` 0x4000004, `exp_in` 127 -> 0x3F800000, `ine` 1.
  - `fract_in` 0x400000C -> 0x3F800002, `ine` 1.
- Exact cancellation: `fract_in` 0, `result_zero_sign` 1, rmode 3 -> 0x80000000, `zero` 1, `ine` 0.
- Overflow: `exp_in` 254, `fract_in` 0x8000000, positive sign:
  - rmode 0 -> 0x7F800000, `overflow` 1, `ine` 1.
  - rmode 1 -> 0x7F7FFFFF.
- Denormal: `exp_in` 1, `fract_in` 0x1000000 -> 0x00200000, `underflow` 0. With `POST_NORM_FTZ_EN`: 0x00000000, `zero`/`underflow`/`ine` 1.
- Backpressure: 5 back-to-back beats with `out_ready` low for 4 cycles, then `reset` pulsed with beats in flight:
  - `in_ready` drops while the output stage is held.
  - The 5 results emerge in order, unchanged.
  - After the reset pulse, `out_valid` is 0 and no stale result appears.
